// File: rtl/data_memory_unit_param.sv
// Parametrised single-port synchronous data memory with a post-reset preload sweep,
// registered reads with a valid strobe and a one-cycle error strobe for rejected requests.
module data_memory_unit_param #(
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 4,
    parameter int DEPTH     = 2**ADDR_W,
    parameter int INIT_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              err
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH-1);

    typedef enum logic {INIT, READY} state_t;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  init_ptr, init_ptr_nxt;
    logic [DATA_W-1:0] mem [DEPTH];

    req_t              req;
    logic              in_range;
    logic [IDX_W-1:0]  req_idx;

    // decoded actions for the current edge
    logic              do_rd;
    logic              rd_oor;
    logic              do_wr;
    logic              reject;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [DATA_W-1:0] mem_wdat;
    logic [DATA_W-1:0] init_pat;

    assign req      = '{rd: rd_en, wr: wr_en, addr: addr, wdata: wdata};
    assign in_range = ({1'b0, req.addr} < DEPTH_L);
    assign req_idx  = req.addr[IDX_W-1:0];
    assign busy     = (state == INIT);
    assign init_pat = (INIT_MODE == 0) ? DATA_W'(init_ptr) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= INIT;
            init_ptr <= '0;
        end else begin
            state    <= state_nxt;
            init_ptr <= init_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_ptr_nxt = init_ptr;
        do_rd        = 1'b0;
        rd_oor       = 1'b0;
        do_wr        = 1'b0;
        reject       = 1'b0;
        case (state)
            INIT: begin
                init_ptr_nxt = init_ptr + 1'b1;
                reject       = req.rd | req.wr;
                if (init_ptr == LAST_IDX) begin
                    state_nxt    = READY;
                    init_ptr_nxt = '0;
                end
            end
            READY: begin
                if (req.rd && req.wr) begin
                    reject = 1'b1;
                end else if (req.rd) begin
                    // out-of-range reads still strobe rvalid, with zero data
                    do_rd  = in_range;
                    rd_oor = !in_range;
                end else if (req.wr) begin
                    do_wr  = in_range;
                    reject = !in_range;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_widx = req_idx;
        mem_wdat = req.wdata;
        if (rst_n) begin
            if (state == INIT) begin
                mem_we   = 1'b1;
                mem_widx = init_ptr;
                mem_wdat = init_pat;
            end else begin
                mem_we   = do_wr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_widx] <= mem_wdat;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= do_rd | rd_oor;
            err    <= reject | rd_oor;
            if (do_rd)
                rdata <= mem[req_idx];
            else if (rd_oor)
                rdata <= '0;
        end
    end

endmodule

// File: tb/tb_data_memory_unit_param.sv
// Scoreboard bench: three memory instances (default, DEPTH=12, INIT_MODE=1) share one clock;
// stimulus pushes expected responses, a negedge monitor pops and compares every strobe.
module tb_data_memory_unit_param;

    logic       clk = 1'b0;
    logic       rst_n  [3];
    logic       rd_en  [3];
    logic       wr_en  [3];
    logic [3:0] addr   [3];
    logic [3:0] wdata  [3];
    logic [3:0] rdata  [3];
    logic       rvalid [3];
    logic       busy   [3];
    logic       err    [3];

    typedef struct {
        int       k;
        logic     rv;
        logic     er;
        logic [3:0] rd;
    } exp_t;

    exp_t       q[$];
    logic [3:0] last_rd [3];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    data_memory_unit_param #(.DATA_W(4), .ADDR_W(4), .DEPTH(16), .INIT_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n[0]), .rd_en(rd_en[0]), .wr_en(wr_en[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .rvalid(rvalid[0]), .busy(busy[0]), .err(err[0]));
    data_memory_unit_param #(.DATA_W(4), .ADDR_W(4), .DEPTH(12), .INIT_MODE(0)) u1 (
        .clk(clk), .rst_n(rst_n[1]), .rd_en(rd_en[1]), .wr_en(wr_en[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .rvalid(rvalid[1]), .busy(busy[1]), .err(err[1]));
    data_memory_unit_param #(.DATA_W(4), .ADDR_W(4), .DEPTH(16), .INIT_MODE(1)) u2 (
        .clk(clk), .rst_n(rst_n[2]), .rd_en(rd_en[2]), .wr_en(wr_en[2]), .addr(addr[2]),
        .wdata(wdata[2]), .rdata(rdata[2]), .rvalid(rvalid[2]), .busy(busy[2]), .err(err[2]));

    // monitor: every strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (rvalid[k] === 1'b1 || err[k] === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp dut%0d: got rvalid=%b err=%b rdata=%h, want no response",
                             k, rvalid[k], err[k], rdata[k]);
                end else begin
                    e = q.pop_front();
                    if (e.k != k || rvalid[k] !== e.rv || err[k] !== e.er || rdata[k] !== e.rd) begin
                        errors++;
                        $display("FAIL resp dut%0d: got rvalid=%b err=%b rdata=%h, want dut%0d rvalid=%b err=%b rdata=%h",
                                 k, rvalid[k], err[k], rdata[k], e.k, e.rv, e.er, e.rd);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic drive(int k, logic r, logic w, logic [3:0] a, logic [3:0] d);
        @(posedge clk); #1;
        for (int j = 0; j < 3; j++) begin
            rd_en[j] = 1'b0; wr_en[j] = 1'b0; addr[j] = '0; wdata[j] = '0;
        end
        rd_en[k] = r; wr_en[k] = w; addr[k] = a; wdata[k] = d;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            for (int j = 0; j < 3; j++) begin
                rd_en[j] = 1'b0; wr_en[j] = 1'b0; addr[j] = '0; wdata[j] = '0;
            end
        end
    endtask

    task automatic rd(int k, logic [3:0] a, logic [3:0] want, logic want_err);
        exp_t e;
        drive(k, 1'b1, 1'b0, a, 4'h0);
        e = '{k: k, rv: 1'b1, er: want_err, rd: want};
        q.push_back(e);
        last_rd[k] = want;
    endtask

    task automatic wr(int k, logic [3:0] a, logic [3:0] d, logic want_err);
        exp_t e;
        drive(k, 1'b0, 1'b1, a, d);
        if (want_err) begin
            e = '{k: k, rv: 1'b0, er: 1'b1, rd: last_rd[k]};
            q.push_back(e);
        end
    endtask

    task automatic both(int k, logic [3:0] a, logic [3:0] d);
        exp_t e;
        drive(k, 1'b1, 1'b1, a, d);
        e = '{k: k, rv: 1'b0, er: 1'b1, rd: last_rd[k]};
        q.push_back(e);
    endtask

    task automatic count_busy(int k, int want, string name);
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy[k] === 1'b1) n++;
        end
        chk(name, n, want);
    endtask

    initial begin
        int nb [3];
        for (int j = 0; j < 3; j++) begin
            rst_n[j] = 1'b0; rd_en[j] = 1'b0; wr_en[j] = 1'b0;
            addr[j] = '0; wdata[j] = '0; last_rd[j] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk($sformatf("reset_state_dut%0d", k),
                int'({rdata[k], rvalid[k], err[k], busy[k]}), int'({4'h0, 1'b0, 1'b0, 1'b1}));

        // release all; busy must last exactly DEPTH cycles
        @(posedge clk); #1;
        for (int j = 0; j < 3; j++) rst_n[j] = 1'b1;
        nb = '{0, 0, 0};
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (busy[k] === 1'b1) nb[k]++;
        end
        chk("busy_cycles_dut0", nb[0], 16);
        chk("busy_cycles_dut1", nb[1], 12);
        chk("busy_cycles_dut2", nb[2], 16);

        // identity preload, read-after-write, conflicting request
        rd(0, 4'd5, 4'h5, 1'b0);
        wr(0, 4'd3, 4'hA, 1'b0);
        rd(0, 4'd3, 4'hA, 1'b0);
        rd(0, 4'd4, 4'h4, 1'b0);
        both(0, 4'd7, 4'h0);
        both(0, 4'd7, 4'h0);
        rd(0, 4'd7, 4'h7, 1'b0);
        rd(0, 4'd15, 4'hF, 1'b0);
        idle(3);

        // DEPTH=12: out-of-range accesses
        wr(1, 4'd13, 4'h1, 1'b1);
        rd(1, 4'd13, 4'h0, 1'b1);
        rd(1, 4'd11, 4'hB, 1'b0);
        rd(1, 4'd12, 4'h0, 1'b1);
        wr(1, 4'd11, 4'h3, 1'b0);
        rd(1, 4'd11, 4'h3, 1'b0);
        idle(3);

        // reset mid-sweep restarts preload and overwrites prior contents
        wr(0, 4'd2, 4'hF, 1'b0);
        rd(0, 4'd2, 4'hF, 1'b0);
        idle(3);
        @(posedge clk); #1 rst_n[0] = 1'b0;
        @(posedge clk); #1 rst_n[0] = 1'b1;
        last_rd[0] = '0;
        repeat (6) @(posedge clk);
        #1 rst_n[0] = 1'b0;
        @(posedge clk); #1 rst_n[0] = 1'b1;
        count_busy(0, 16, "busy_after_midinit_reset");
        rd(0, 4'd2, 4'h2, 1'b0);
        rd(0, 4'd3, 4'h3, 1'b0);
        idle(3);

        // INIT_MODE=1: zero preload; requests during busy are rejected
        for (int a = 0; a < 16; a++) rd(2, 4'(a), 4'h0, 1'b0);
        wr(2, 4'd5, 4'h6, 1'b0);
        rd(2, 4'd5, 4'h6, 1'b0);
        idle(3);
        @(posedge clk); #1 rst_n[2] = 1'b0;
        @(posedge clk); #1 rst_n[2] = 1'b1;
        last_rd[2] = '0;
        rd(2, 4'd3, 4'h0, 1'b1);
        q[q.size()-1].rv = 1'b0;
        wr(2, 4'd3, 4'h9, 1'b1);
        idle(25);
        rd(2, 4'd3, 4'h0, 1'b0);
        rd(2, 4'd5, 4'h0, 1'b0);
        idle(5);

        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
